riscoffee_fetch: RTL

Instruction fetch stage for the riscoffee pipeline, directly upstream of `riscoffee_decode`. It generates sequential fetch addresses, issues requests to instruction memory, and buffers returned words in a 2-entry FIFO. It presents `INST_CODE`/`PC`/`READY` to decode, honours downstream stalls, and handles redirects from branch/jump/trap resolution by flushing the buffer and discarding in-flight responses.

---
 rtl/riscoffee_fetch.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/riscoffee_fetch.sv
// riscoffee_fetch -- instruction fetch stage feeding riscoffee_decode.
//
// Generates sequential word-aligned fetch addresses, issues them to
// instruction memory, and buffers the returned words in a 2-entry FIFO whose
// head is presented to decode. Redirects flush the FIFO, re-target the fetch
// address and mark every in-flight response as stale so it is dropped.
//
// Ports
//   CLK          clock, all state on posedge
//   RST          synchronous active-high reset
//   STALL        decode hold; the head entry is not consumed while high
//   REDIRECT     re-target fetch to REDIRECT_PC (branch/jump/trap)
//   REDIRECT_PC  redirect target, low two bits ignored
//   IMEM_REQ     fetch request valid
//   IMEM_ADDR    fetch address (word aligned, held while unaccepted)
//   IMEM_ACK     request accepted this cycle when IMEM_REQ is high
//   IMEM_RVALID  in-order read data valid, >=1 cycle after acceptance
//   IMEM_RDATA   returned instruction word
//   READY        INST_CODE/PC valid
//   INST_CODE    FIFO head instruction, NOP (0x13) when not READY
//   PC           address of INST_CODE, 0 when not READY
//
// Credit: a request may go out only while the words already owed to the FIFO
// (buffered + outstanding) stay below its depth. The word decode consumes
// this cycle frees its slot immediately, so the credit test subtracts the
// current pop. That is what lets a 1-cycle memory sustain one instruction per
// cycle with only two entries, while keeping count + outstanding <= 2 at every
// edge. IMEM_REQ is therefore decoded from registered state (FSM state,
// count, outstanding, head valid) plus the current STALL; IMEM_ADDR is the
// fetch-pc register itself. Nothing on the decode side depends on IMEM_RDATA
// combinationally.

module riscoffee_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        READY,
  output logic [31:0] INST_CODE,
  output logic [31:0] PC
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_reg;

  logic [31:0] fpc_reg;      // next address to request
  logic [31:0] fpc_next;
  logic [31:0] rpc_reg;      // address of the next word that will be pushed
  logic [31:0] rpc_next;
  logic [1:0]  count_reg;    // buffered entries
  logic [1:0]  count_next;
  logic [1:0]  outst_reg;    // accepted, not yet returned
  logic [1:0]  outst_next;
  logic [1:0]  stale_reg;    // returns still to be discarded
  logic [1:0]  stale_next;

  // Entry 0 is always the head; entry 1 shifts down on a pop.
  logic [31:0] fifo_pc_reg   [2];
  logic [31:0] fifo_inst_reg [2];

  logic [31:0] redirect_target;
  logic        pop;
  logic        accept;
  logic        push;
  logic        drop;
  logic [2:0]  credit_used;
  logic [1:0]  count_after_pop;

  // Masking (rather than slicing) keeps every bit of REDIRECT_PC in use.
  assign redirect_target = REDIRECT_PC & ~32'h0000_0003;

  // ---------------------------------------------------------------------
  // Decode-side outputs: straight from the registered FIFO head.
  // ---------------------------------------------------------------------
  assign READY     = (count_reg != 2'd0);
  assign INST_CODE = READY ? fifo_inst_reg[0] : NOP_INST;
  assign PC        = READY ? fifo_pc_reg[0]   : 32'h0000_0000;

  assign pop = READY && !STALL;

  // ---------------------------------------------------------------------
  // Memory-side request.
  // ---------------------------------------------------------------------
  assign credit_used = {1'b0, count_reg} + {1'b0, outst_reg} - {2'b00, pop};
  assign IMEM_REQ    = (state_reg == RUN) && (credit_used < 3'd2);
  assign IMEM_ADDR   = fpc_reg;

  assign accept = IMEM_REQ && IMEM_ACK;

  // A response is dropped while stale returns are owed; a clean response
  // arriving in a redirect cycle belongs to the old path and is dropped too.
  assign drop = IMEM_RVALID && (stale_reg != 2'd0);
  assign push = IMEM_RVALID && (stale_reg == 2'd0) && !REDIRECT;

  assign count_after_pop = count_reg - {1'b0, pop};

  // ---------------------------------------------------------------------
  // Next-state arithmetic.
  // ---------------------------------------------------------------------
  always_comb begin
    outst_next = outst_reg + {1'b0, accept} - {1'b0, IMEM_RVALID};
    fpc_next   = fpc_reg;
    rpc_next   = rpc_reg;
    count_next = count_reg;
    stale_next = stale_reg;

    if (REDIRECT) begin
      // Everything still owed by memory after this cycle's accept/return
      // belongs to the abandoned path.
      fpc_next   = redirect_target;
      rpc_next   = redirect_target;
      count_next = 2'd0;
      stale_next = outst_next;
    end else begin
      if (accept) begin
        fpc_next = fpc_reg + 32'd4;
      end
      if (push) begin
        rpc_next = rpc_reg + 32'd4;
      end
      count_next = count_after_pop + {1'b0, push};
      stale_next = stale_reg - {1'b0, drop};
    end
  end

  // ---------------------------------------------------------------------
  // Control state and FSM.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= BOOT;
      fpc_reg   <= RESET_PC;
      rpc_reg   <= RESET_PC;
      count_reg <= 2'd0;
      outst_reg <= 2'd0;
      stale_reg <= 2'd0;
    end else begin
      fpc_reg   <= fpc_next;
      rpc_reg   <= rpc_next;
      count_reg <= count_next;
      outst_reg <= outst_next;
      stale_reg <= stale_next;

      case (state_reg)
        BOOT: begin
          state_reg <= RUN;
        end
        RUN: begin
          if (REDIRECT && (stale_next != 2'd0)) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          // Requests resume the cycle after the last stale return; a
          // redirect here has already recomputed stale_next.
          if (stale_next == 2'd0) begin
            state_reg <= RUN;
          end
        end
        default: begin
          state_reg <= BOOT;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FIFO storage. Contents need no reset: count_reg qualifies them.
  // On push+pop the new word lands behind the surviving entry, so order is
  // preserved and count is unchanged.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (pop) begin
      fifo_pc_reg[0]   <= fifo_pc_reg[1];
      fifo_inst_reg[0] <= fifo_inst_reg[1];
    end
    if (push) begin
      if (count_after_pop == 2'd0) begin
        fifo_pc_reg[0]   <= rpc_reg;
        fifo_inst_reg[0] <= IMEM_RDATA;
      end else begin
        fifo_pc_reg[1]   <= rpc_reg;
        fifo_inst_reg[1] <= IMEM_RDATA;
      end
    end
  end

endmodule
